// File: rtl/bram_rr_arbiter_if.sv
// Requester-side handshake bundle plus the shared BRAM port of the
// round-robin arbiter. The arbiter takes the slave view; the requesters
// and the BRAM together take the master view.
interface bram_rr_arbiter_if #(
    parameter int NUM_REQ        = 4,
    parameter int RAM_DATA_WIDTH = 8,
    parameter int RAM_ADDR_WIDTH = 4
);
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0]                req_wr;
    logic [NUM_REQ*RAM_ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*RAM_DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                rsp_valid;
    logic [RAM_DATA_WIDTH-1:0]         rsp_data;
    logic                              ram_wr;
    logic [RAM_ADDR_WIDTH-1:0]         ram_addr;
    logic [RAM_DATA_WIDTH-1:0]         ram_data_in;
    logic [RAM_DATA_WIDTH-1:0]         ram_data_out;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, ram_data_out,
        input  req_ready, rsp_valid, rsp_data, ram_wr, ram_addr, ram_data_in
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, ram_data_out,
        output req_ready, rsp_valid, rsp_data, ram_wr, ram_addr, ram_data_in
    );
endinterface

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter serializing NUM_REQ requesters onto one BRAM port.
// One grant per cycle, registered command issue, and read data returned
// two cycles after the grant with a one-hot tag to the originator.
module bram_rr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int RAM_DATA_WIDTH = 8,
    parameter int RAM_ADDR_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    bram_rr_arbiter_if.slave bus
);
    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [TAG_W-1:0]          ptr;
    logic [TAG_W-1:0]          ptr_nxt;
    logic [TAG_W-1:0]          grant_idx;
    logic                      grant_vld;
    logic [2*NUM_REQ-1:0]      rot;
    logic [NUM_REQ-1:0]        ready_c;
    logic                      sel_wr;
    logic [RAM_ADDR_WIDTH-1:0] sel_addr;
    logic [RAM_DATA_WIDTH-1:0] sel_wdata;

    logic                      wr_p1;
    logic [RAM_ADDR_WIDTH-1:0] addr_p1;
    logic [RAM_DATA_WIDTH-1:0] wdata_p1;
    logic                      vld_p1;
    logic                      rd_p1;
    logic [TAG_W-1:0]          tag_p1;
    logic                      vld_p2;
    logic [TAG_W-1:0]          tag_p2;
    logic [NUM_REQ-1:0]        rsp_vld_c;

    // Rotating priority search: first valid requester at or after ptr wins.
    always_comb begin
        int cand;
        int nxt;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        nxt       = 0;
        rot       = {bus.req_valid, bus.req_valid} >> ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && rot[i]) begin
                cand = int'(ptr) + i;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                grant_vld = 1'b1;
                grant_idx = TAG_W'(cand);
            end
        end
        // Nothing may be granted while reset holds the block idle.
        if (!rst) begin
            grant_vld = 1'b0;
        end
        nxt = int'(grant_idx) + 1;
        if (nxt >= NUM_REQ) begin
            nxt = 0;
        end
        ptr_nxt = TAG_W'(nxt);
    end

    // One-hot ready and mux of the winner's command fields.
    always_comb begin
        ready_c   = '0;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vld && grant_idx == TAG_W'(i)) begin
                ready_c[i] = 1'b1;
                sel_wr     = bus.req_wr[i];
                sel_addr   = bus.req_addr[i*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
                sel_wdata  = bus.req_wdata[i*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
            end
        end
    end

    // Pointer advance and issue stage; address/data hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            wr_p1    <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
            vld_p1   <= 1'b0;
            rd_p1    <= 1'b0;
            tag_p1   <= '0;
        end else if (grant_vld) begin
            ptr      <= ptr_nxt;
            wr_p1    <= sel_wr;
            addr_p1  <= sel_addr;
            wdata_p1 <= sel_wdata;
            vld_p1   <= 1'b1;
            rd_p1    <= ~sel_wr;
            tag_p1   <= grant_idx;
        end else begin
            wr_p1  <= 1'b0;
            vld_p1 <= 1'b0;
        end
    end

    // Tag tracks the BRAM access cycle so it lines up with ram_data_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2 <= 1'b0;
            tag_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1 & rd_p1;
            tag_p2 <= tag_p1;
        end
    end

    // Decode the response tag into the one-hot read-data-valid.
    always_comb begin
        rsp_vld_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vld_p2 && tag_p2 == TAG_W'(i)) begin
                rsp_vld_c[i] = 1'b1;
            end
        end
    end

    assign bus.req_ready   = ready_c;
    assign bus.rsp_valid   = rsp_vld_c;
    assign bus.rsp_data    = rst ? bus.ram_data_out : '0;
    assign bus.ram_wr      = wr_p1;
    assign bus.ram_addr    = addr_p1;
    assign bus.ram_data_in = wdata_p1;
endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Directed bench for bram_rr_arbiter with a read-first, registered-output
// BRAM model on the shared port.
module tb_bram_rr_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    bram_rr_arbiter_if #(.NUM_REQ(NR), .RAM_DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW)) bus ();

    bram_rr_arbiter #(.NUM_REQ(NR), .RAM_DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: read-first, one-cycle registered read; mem[a] = {4'hA, a}.
    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = {4'hA, 4'(i)};
        bus.ram_data_out = '0;
    end
    always @(posedge clk) begin
        bus.ram_data_out <= mem[bus.ram_addr];
        if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_data_in;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]          = v;
        bus.req_wr[i]             = w;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clr_req();
        bus.req_valid = '0;
        bus.req_wr    = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, bus.req_ready, 0);
        chk({tag, "_rspv"},  bus.rsp_valid, 0);
        chk({tag, "_rspd"},  bus.rsp_data, 0);
        chk({tag, "_wr"},    bus.ram_wr, 0);
        chk({tag, "_addr"},  bus.ram_addr, 0);
        chk({tag, "_din"},   bus.ram_data_in, 0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.req_wr    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Power-on reset with requests pending: everything stays 0.
        cyc();
        bus.req_valid = 4'b1111;
        smp();
        chk_all_zero("por");
        cyc();
        clr_req();
        rst = 1'b1;

        // Mid-stream reset: req1 read of addr 6 in flight.
        cyc();
        set_req(1, 1'b1, 1'b0, 4'd6, 8'h00);
        smp();
        chk("t1_grant1", bus.req_ready, 4'b0010);
        cyc();
        clr_req();
        smp();
        chk("t1_issue_addr", bus.ram_addr, 6);
        set_req(0, 1'b1, 1'b0, 4'd3, 8'h00);
        set_req(3, 1'b1, 1'b0, 4'd8, 8'h00);
        #1;
        rst = 1'b0;
        #1;
        chk_all_zero("t1_async");
        cyc();
        cyc();
        rst = 1'b1;
        smp();
        chk("t1_ptr0_grant", bus.req_ready, 4'b0001);
        chk("t1_no_stale_rsp", bus.rsp_valid, 0);
        cyc();
        clr_req();
        smp();
        chk("t1_rsp_quiet", bus.rsp_valid, 0);
        chk("t1_addr3", bus.ram_addr, 3);
        cyc();
        smp();
        chk("t1_rspv", bus.rsp_valid, 4'b0001);
        chk("t1_rspd", bus.rsp_data, 8'hA3);

        // Single read: req2 reads addr 5.
        cyc();
        set_req(2, 1'b1, 1'b0, 4'd5, 8'h00);
        smp();
        chk("t2_ready", bus.req_ready, 4'b0100);
        cyc();
        clr_req();
        smp();
        chk("t2_addr", bus.ram_addr, 5);
        chk("t2_wr", bus.ram_wr, 0);
        chk("t2_rsp_early", bus.rsp_valid, 0);
        cyc();
        smp();
        chk("t2_rspv", bus.rsp_valid, 4'b0100);
        chk("t2_rspd", bus.rsp_data, 8'hA5);

        // Sparse contention with ptr=3: req0 then req2.
        cyc();
        set_req(0, 1'b1, 1'b0, 4'd1, 8'h00);
        set_req(2, 1'b1, 1'b0, 4'd7, 8'h00);
        smp();
        chk("t5_grant0", bus.req_ready, 4'b0001);
        cyc();
        bus.req_valid[0] = 1'b0;
        smp();
        chk("t5_grant2", bus.req_ready, 4'b0100);
        chk("t5_addr1", bus.ram_addr, 1);
        cyc();
        clr_req();
        smp();
        chk("t5_idle", bus.req_ready, 0);
        chk("t5_addr7", bus.ram_addr, 7);
        chk("t5_rspv0", bus.rsp_valid, 4'b0001);
        chk("t5_rspd0", bus.rsp_data, 8'hA1);
        cyc();
        smp();
        chk("t5_rspv2", bus.rsp_valid, 4'b0100);
        chk("t5_rspd2", bus.rsp_data, 8'hA7);

        // Write 0x3C to addr 9, then read it back on the next cycle.
        cyc();
        set_req(1, 1'b1, 1'b1, 4'd9, 8'h3C);
        smp();
        chk("t3_wgrant", bus.req_ready, 4'b0010);
        chk("t3_rsp_none0", bus.rsp_valid, 0);
        cyc();
        set_req(1, 1'b1, 1'b0, 4'd9, 8'h00);
        smp();
        chk("t3_rgrant", bus.req_ready, 4'b0010);
        chk("t3_wr", bus.ram_wr, 1);
        chk("t3_waddr", bus.ram_addr, 9);
        chk("t3_wdata", bus.ram_data_in, 8'h3C);
        cyc();
        clr_req();
        smp();
        chk("t3_rd_wr0", bus.ram_wr, 0);
        chk("t3_raddr", bus.ram_addr, 9);
        chk("t3_no_wrsp", bus.rsp_valid, 0);
        cyc();
        smp();
        chk("t3_rspv", bus.rsp_valid, 4'b0010);
        chk("t3_rspd", bus.rsp_data, 8'h3C);

        // Idle for 5 cycles; ptr must stay at 2.
        for (int k = 0; k < 5; k++) begin
            cyc();
            smp();
            chk($sformatf("t6_wr_%0d", k), bus.ram_wr, 0);
            chk($sformatf("t6_rsp_%0d", k), bus.rsp_valid, 0);
            chk($sformatf("t6_rdy_%0d", k), bus.req_ready, 0);
        end
        cyc();
        set_req(0, 1'b1, 1'b0, 4'd2, 8'h00);
        set_req(3, 1'b1, 1'b0, 4'd4, 8'h00);
        smp();
        chk("t6_ptr_held", bus.req_ready, 4'b1000);
        cyc();
        clr_req();
        cyc();
        smp();
        chk("t6_rspv", bus.rsp_valid, 4'b1000);
        chk("t6_rspd", bus.rsp_data, 8'hA4);

        // Fairness: all four read continuously for 8 cycles from ptr=0.
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, 4'(10 + i), 8'h00);
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k == 0) bus.req_valid = 4'b1111;
            if (k == 8) bus.req_valid = 4'b0000;
            smp();
            if (k < 8) chk($sformatf("t4_rdy_%0d", k), bus.req_ready, 1 << (k % 4));
            else       chk($sformatf("t4_rdy_%0d", k), bus.req_ready, 0);
            if (k >= 1 && k <= 8)
                chk($sformatf("t4_addr_%0d", k), bus.ram_addr, 10 + ((k - 1) % 4));
            if (k >= 2) begin
                chk($sformatf("t4_rspv_%0d", k), bus.rsp_valid, 1 << ((k - 2) % 4));
                chk($sformatf("t4_rspd_%0d", k), bus.rsp_data, 8'hAA + ((k - 2) % 4));
            end else begin
                chk($sformatf("t4_rspv_%0d", k), bus.rsp_valid, 0);
            end
        end
        cyc();
        smp();
        chk("t4_drain", bus.rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
